// File: rtl/gpio_slave_pkg.sv
// rtl/gpio_slave_pkg.sv - shared field offsets, frame codes and FSM state type for gpio_slave
package gpio_slave_pkg;

  localparam int PKT_VALUE_LSB  = 0;
  localparam int PKT_SEL_LSB    = 48;
  localparam int PKT_SEL_W      = 3;

  localparam int CFG_OE_LSB     = 0;
  localparam int CFG_SMP_EN_BIT = 8;
  localparam int CFG_HOLD_LSB   = 16;
  localparam int CFG_HOLD_W     = 16;

  // sel codes 6 and 7 are frame codes that always carry the full six bytes
  localparam logic [2:0] SEL_FRAME_A = 3'd6;
  localparam logic [2:0] SEL_FRAME_B = 3'd7;
  localparam logic [2:0] MAX_BYTES   = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DRIVE = 2'd3
  } state_e;

  function automatic logic [2:0] sel_to_nbytes(input logic [2:0] sel);
    if (sel == 3'd0) return 3'd1;
    if (sel == SEL_FRAME_A || sel == SEL_FRAME_B) return MAX_BYTES;
    return sel;
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// rtl/gpio_in_sync.sv - 2-flop pin synchronizer with optional debounce filter
// Debounce filter is built only when GPIO_SLV_DEBOUNCE_EN is defined.
module gpio_in_sync #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEBOUNCE_CLKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] meta_q, meta_d;
  logic [DATA_WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

`ifdef GPIO_SLV_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CLKS + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CLKS);

  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] filt_q, filt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // cnt tracks how many consecutive cycles last_q has been seen unchanged
  always_comb begin
    last_d = sync_q;
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync_q != last_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_DONE) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == CNT_DONE) filt_d = last_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = filt_q;
`else
  localparam int unused_debounce_clks = DEBOUNCE_CLKS;
  assign dout = sync_q;
`endif

endmodule

// File: rtl/gpio_slave.sv
// rtl/gpio_slave.sv - GPIO slave: plays FIFO packets onto pins, pushes input changes to read FIFO
// Optional input debounce: define GPIO_SLV_DEBOUNCE_EN.
module gpio_slave
  import gpio_slave_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int PKT_WIDTH     = 51,
  parameter int VALUE_WIDTH   = 48,
  parameter int CFG_WIDTH     = 32,
  parameter int DEBOUNCE_CLKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CFG_WIDTH-1:0]  cfg_word,
  input  logic                  pkt_empty,
  output logic                  pkt_rd_en,
  input  logic [PKT_WIDTH-1:0]  pkt_data,
  input  logic                  smp_full,
  output logic                  smp_wr_en,
  output logic [DATA_WIDTH-1:0] smp_data,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic [DATA_WIDTH-1:0] gpio_oe,
  output logic                  busy,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  state_e                   state_q, state_d;
  logic [VALUE_WIDTH-1:0]   value_q, value_d;
  logic [2:0]               nbytes_q, nbytes_d;
  logic [2:0]               idx_q, idx_d;
  logic [CFG_HOLD_W-1:0]    hold_q, hold_d;
  logic [CFG_HOLD_W-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    out_q, out_d;
  logic [DATA_WIDTH-1:0]    oe_q, oe_d;

  logic [DATA_WIDTH-1:0]    s_filt;
  logic [DATA_WIDTH-1:0]    samp_q, samp_d;
  logic [DATA_WIDTH-1:0]    cmp_q, cmp_d;
  logic [DATA_WIDTH-1:0]    prev_q, prev_d;
  logic                     smp_wr_q, smp_wr_d;
  logic [DATA_WIDTH-1:0]    smp_data_q, smp_data_d;
  logic                     ovf_q, ovf_d;

  logic [CFG_HOLD_W-1:0]    cfg_hold;
  logic [VALUE_WIDTH-1:0]   value_shift;
  logic [DATA_WIDTH-1:0]    cur_byte;
  logic                     smp_en, changed, do_push, do_drop;
  logic                     unused_cfg;

  assign cfg_hold    = cfg_word[CFG_HOLD_LSB +: CFG_HOLD_W];
  assign value_shift = value_q >> (DATA_WIDTH * int'(idx_q));
  assign cur_byte    = value_shift[DATA_WIDTH-1:0];
  assign unused_cfg  = ^cfg_word[CFG_HOLD_LSB-1:CFG_SMP_EN_BIT+1];

  gpio_in_sync #(
    .DATA_WIDTH    (DATA_WIDTH),
    .DEBOUNCE_CLKS (DEBOUNCE_CLKS)
  ) u_in_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (gpio_in),
    .dout  (s_filt)
  );

  // Output FSM: pacing is latched at LOAD so cfg changes only affect later packets
  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    nbytes_d = nbytes_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    case (state_q)
      ST_IDLE: begin
        if (!pkt_empty) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        value_d  = pkt_data[PKT_VALUE_LSB +: VALUE_WIDTH];
        nbytes_d = sel_to_nbytes(pkt_data[PKT_SEL_LSB +: PKT_SEL_W]);
        hold_d   = (cfg_hold == '0) ? CFG_HOLD_W'(1) : cfg_hold;
        idx_d    = '0;
        cnt_d    = '0;
        state_d  = ST_DRIVE;
      end
      ST_DRIVE: begin
        out_d = cur_byte;
        if (cnt_q == hold_q - 1'b1) begin
          cnt_d = '0;
          if (idx_q == nbytes_q - 3'd1) state_d = ST_IDLE;
          else idx_d = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Input path: the extra compare stage keeps data and strobe aligned on the push
  always_comb begin
    smp_en  = cfg_word[CFG_SMP_EN_BIT];
    changed = (cmp_q != prev_q);
    do_push = changed && smp_en && !smp_full;
    do_drop = changed && smp_en && smp_full;

    oe_d       = cfg_word[CFG_OE_LSB +: DATA_WIDTH];
    samp_d     = s_filt;
    cmp_d      = s_filt & ~oe_q;
    prev_d     = cmp_q;
    smp_wr_d   = do_push;
    smp_data_d = do_push ? samp_q : smp_data_q;
    ovf_d      = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (do_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      value_q    <= '0;
      nbytes_q   <= '0;
      idx_q      <= '0;
      hold_q     <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      oe_q       <= '0;
      samp_q     <= '0;
      cmp_q      <= '0;
      prev_q     <= '0;
      smp_wr_q   <= 1'b0;
      smp_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      nbytes_q   <= nbytes_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      oe_q       <= oe_d;
      samp_q     <= samp_d;
      cmp_q      <= cmp_d;
      prev_q     <= prev_d;
      smp_wr_q   <= smp_wr_d;
      smp_data_q <= smp_data_d;
      ovf_q      <= ovf_d;
    end
  end

  assign pkt_rd_en = (state_q == ST_FETCH);
  assign busy      = (state_q != ST_IDLE);
  assign gpio_out  = out_q;
  assign gpio_oe   = oe_q;
  assign smp_wr_en = smp_wr_q;
  assign smp_data  = smp_data_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_gpio_slave.sv
// tb/tb_gpio_slave.sv - table-driven self-checking bench for gpio_slave
module tb_gpio_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cfg_word = '0;
  logic        pkt_empty;
  logic        pkt_rd_en;
  logic [50:0] pkt_data = '0;
  logic        smp_full = 1'b0;
  logic        smp_wr_en;
  logic [7:0]  smp_data;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_oe;
  logic        busy;
  logic        ovf;
  logic        ovf_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [50:0] mem [16];
  int pushes = 0;
  int pops = 0;
  int bad_pops = 0;

  gpio_slave dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_word  (cfg_word),
    .pkt_empty (pkt_empty),
    .pkt_rd_en (pkt_rd_en),
    .pkt_data  (pkt_data),
    .smp_full  (smp_full),
    .smp_wr_en (smp_wr_en),
    .smp_data  (smp_data),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_oe   (gpio_oe),
    .busy      (busy),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  // Write FIFO model: data appears the cycle after the pop strobe
  assign pkt_empty = (pushes == pops);
  always @(posedge clk) begin
    if (pkt_rd_en) begin
      if (pushes == pops) bad_pops <= bad_pops + 1;
      else begin
        pkt_data <= mem[pops];
        pops     <= pops + 1;
      end
    end
  end

  typedef struct {
    logic        push;
    logic [50:0] pkt;
    logic [31:0] cfg;
    logic [7:0]  gin;
    logic        full;
    logic        clr;
    logic        e_rd;
    logic        e_busy;
    logic [7:0]  e_out;
    logic [7:0]  e_oe;
    logic        e_wr;
    logic [7:0]  e_sdata;
    logic        e_ovf;
  } vec_t;

  vec_t vt [64];
  int   nv = 0;

  task automatic add(input logic push, input logic [50:0] pkt, input logic [31:0] cfg,
                     input logic [7:0] gin, input logic full, input logic clr,
                     input logic e_rd, input logic e_busy, input logic [7:0] e_out,
                     input logic [7:0] e_oe, input logic e_wr, input logic [7:0] e_sdata,
                     input logic e_ovf);
    vt[nv] = '{push, pkt, cfg, gin, full, clr, e_rd, e_busy, e_out, e_oe, e_wr, e_sdata, e_ovf};
    nv++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input logic [50:0] pkt);
    mem[pushes] = pkt;
    pushes++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] CA = 32'h000201FF;
  localparam logic [31:0] CB = 32'h000401FF;
  localparam logic [31:0] CC = 32'h000001B5;
  localparam logic [50:0] PA = {3'd0, 48'h5A};
  localparam logic [50:0] PB = {3'd3, 48'h332211};

  logic [7:0] h1e [10];
  int rd_cnt, first_rd, second_rd, pops_at_rst;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // single byte, P=2
    add(1, PA, CA, 8'h00, 0, 0, 1, 1, 8'h00, 8'hFF, 0, 8'h00, 0);
    add(0, '0, CA, 8'h00, 0, 0, 0, 1, 8'h00, 8'hFF, 0, 8'h00, 0);
    add(0, '0, CA, 8'h00, 0, 0, 0, 1, 8'h00, 8'hFF, 0, 8'h00, 0);
    add(0, '0, CA, 8'h00, 0, 0, 0, 1, 8'h5A, 8'hFF, 0, 8'h00, 0);
    add(0, '0, CA, 8'h00, 0, 0, 0, 0, 8'h5A, 8'hFF, 0, 8'h00, 0);
    add(0, '0, CA, 8'h00, 0, 0, 0, 0, 8'h5A, 8'hFF, 0, 8'h00, 0);
    // three bytes, P=4
    add(1, PB, CB, 8'h00, 0, 0, 1, 1, 8'h5A, 8'hFF, 0, 8'h00, 0);
    for (int i = 0; i < 2; i++) add(0, '0, CB, 8'h00, 0, 0, 0, 1, 8'h5A, 8'hFF, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) add(0, '0, CB, 8'h00, 0, 0, 0, 1, 8'h11, 8'hFF, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) add(0, '0, CB, 8'h00, 0, 0, 0, 1, 8'h22, 8'hFF, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) add(0, '0, CB, 8'h00, 0, 0, 0, 1, 8'h33, 8'hFF, 0, 8'h00, 0);
    for (int i = 0; i < 2; i++) add(0, '0, CB, 8'h00, 0, 0, 0, 0, 8'h33, 8'hFF, 0, 8'h00, 0);
    // input sampling, pins 0,2,4,5,7 are outputs
    add(0, '0, CC, 8'h00, 0, 0, 0, 0, 8'h33, 8'hB5, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) add(0, '0, CC, 8'h4A, 0, 0, 0, 0, 8'h33, 8'hB5, 0, 8'h00, 0);
    add(0, '0, CC, 8'h4A, 0, 0, 0, 0, 8'h33, 8'hB5, 1, 8'h4A, 0);
    add(0, '0, CC, 8'h4A, 0, 0, 0, 0, 8'h33, 8'hB5, 0, 8'h4A, 0);
    for (int i = 0; i < 5; i++) add(0, '0, CC, 8'h4B, 0, 0, 0, 0, 8'h33, 8'hB5, 0, 8'h4A, 0);
    for (int i = 0; i < 3; i++) add(0, '0, CC, 8'h0B, 1, 0, 0, 0, 8'h33, 8'hB5, 0, 8'h4A, 0);
    add(0, '0, CC, 8'h0B, 1, 0, 0, 0, 8'h33, 8'hB5, 0, 8'h4A, 1);
    for (int i = 0; i < 3; i++) add(0, '0, CC, 8'h4B, 1, 0, 0, 0, 8'h33, 8'hB5, 0, 8'h4A, 1);
    add(0, '0, CC, 8'h4B, 1, 1, 0, 0, 8'h33, 8'hB5, 0, 8'h4A, 1);
    add(0, '0, CC, 8'h4B, 1, 1, 0, 0, 8'h33, 8'hB5, 0, 8'h4A, 0);
    add(0, '0, CC, 8'h4B, 0, 0, 0, 0, 8'h33, 8'hB5, 0, 8'h4A, 0);

    // reset state, with a config that would otherwise enable every pin
    cfg_word = CA;
    for (int i = 0; i < 3; i++) step();
    chk("rst gpio_out", gpio_out, 8'h00);
    chk("rst gpio_oe", gpio_oe, 8'h00);
    chk("rst busy", busy, 1'b0);
    chk("rst pkt_rd_en", pkt_rd_en, 1'b0);
    chk("rst smp_wr_en", smp_wr_en, 1'b0);
    chk("rst smp_data", smp_data, 8'h00);
    chk("rst ovf", ovf, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      cfg_word = vt[i].cfg;
      gpio_in  = vt[i].gin;
      smp_full = vt[i].full;
      ovf_clr  = vt[i].clr;
      if (vt[i].push) push_pkt(vt[i].pkt);
      step();
      chk($sformatf("v%0d pkt_rd_en", i), pkt_rd_en, vt[i].e_rd);
      chk($sformatf("v%0d busy", i), busy, vt[i].e_busy);
      chk($sformatf("v%0d gpio_out", i), gpio_out, vt[i].e_out);
      chk($sformatf("v%0d gpio_oe", i), gpio_oe, vt[i].e_oe);
      chk($sformatf("v%0d smp_wr_en", i), smp_wr_en, vt[i].e_wr);
      chk($sformatf("v%0d smp_data", i), smp_data, vt[i].e_sdata);
      chk($sformatf("v%0d ovf", i), ovf, vt[i].e_ovf);
    end

    // six-byte frame at P=1 with a second packet queued; cfg changes mid-packet
    gpio_in = 8'h00;
    smp_full = 1'b0;
    ovf_clr = 1'b0;
    cfg_word = 32'h000101FF;
    for (int i = 0; i < 4; i++) step();
    h1e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h06, 8'h06, 8'h06, 8'hA5};
    push_pkt({3'd7, 48'h060504030201});
    push_pkt({3'd1, 48'h0000000000A5});
    rd_cnt = 0;
    first_rd = -1;
    second_rd = -1;
    for (int c = 0; c <= 12; c++) begin
      if (c == 4) cfg_word = 32'h000500F0;
      step();
      if (pkt_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = c;
        else second_rd = c;
      end
      if (c >= 3) chk($sformatf("h1 gpio_out c%0d", c), gpio_out, h1e[c-3]);
      if (c == 4) chk("h1 oe follows cfg", gpio_oe, 8'hF0);
    end
    chk("h1 rd count", rd_cnt, 2);
    chk("h1 first rd cycle", first_rd, 0);
    chk("h1 second rd cycle", second_rd, 9);
    for (int c = 0; c < 40 && busy; c++) step();
    chk("h1 idle after second", busy, 1'b0);
    chk("h1 last byte held", gpio_out, 8'hA5);

    // reset during DRIVE of a five-byte packet
    cfg_word = 32'h000300FF;
    push_pkt({3'd5, 48'h000504030201});
    for (int c = 0; c < 30 && gpio_out !== 8'h02; c++) step();
    chk("h2 reached byte1", gpio_out, 8'h02);
    pops_at_rst = pops;
    #2;
    rst_n = 1'b0;
    #1;
    chk("h2 rst gpio_out", gpio_out, 8'h00);
    chk("h2 rst gpio_oe", gpio_oe, 8'h00);
    chk("h2 rst busy", busy, 1'b0);
    chk("h2 rst pkt_rd_en", pkt_rd_en, 1'b0);
    chk("h2 rst ovf", ovf, 1'b0);
    step();
    rst_n = 1'b1;
    rd_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (pkt_rd_en || busy) rd_cnt++;
    end
    chk("h2 no re-read after reset", rd_cnt, 0);
    chk("h2 pops unchanged", pops, pops_at_rst);
    cfg_word = 32'h000000FF;
    push_pkt({3'd2, 48'h00000000BEEF});
    for (int c = 0; c <= 5; c++) begin
      step();
      if (c == 0) chk("h2 next pop", pkt_rd_en, 1'b1);
      if (c == 3) chk("h2 byte0 P=1", gpio_out, 8'hEF);
      if (c == 4) chk("h2 byte1 P=1", gpio_out, 8'hBE);
      if (c == 4) chk("h2 idle after 2 bytes", busy, 1'b0);
    end

    chk("fifo pops match pushes", pops, pushes);
    chk("no pop while empty", bad_pops, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
